simd_addxor_recon: RTL and testbench

- Inverse of the SIMD subtract/XOR share stage.
- Recombines a masked share z with its mask y:
  - Arithmetic mode: x = z + y per lane, mod 2^w.
  - Boolean mode: x = z ^ y.
- Sits on the consumer side of the correlated-random pipeline, ahead of the result FIFO.
- Pipelined with valid/ready handshakes on both sides; carries a per-beat tag so the consumer can match results to requests.

---
 rtl/simd_addxor_recon_pkg.sv | 37 +++
 rtl/simd_addxor_recon_chunk_csel_add.sv | 53 +++++
 rtl/simd_addxor_recon.sv | 181 ++++++++++++++++++
 tb/tb_simd_addxor_recon.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_addxor_recon_pkg.sv
// Shared types and helpers for the SIMD share-recombination datapath.
// 128-bit share vector, split into lanes of 8/16/32/64 bits.
package simd_addxor_recon_pkg;

  localparam int P = 128;

  typedef logic [P-1:0] prng_t;

  typedef struct packed {
    logic b;
  } mode_t;

  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W32 = 2'd2,
    W64 = 2'd3
  } width_t;

  typedef struct packed {
    logic c0;
    logic c1;
  } chunk_carry_t;

  // One bit set at the LSB of every lane for the given lane width.
  function automatic prng_t make_carry_mask(input width_t w);
    prng_t m;
    int    lw;
    m  = '0;
    lw = 8 << int'(w);
    for (int i = 0; i < P; i++) begin
      m[i] = ((i % lw) == 0);
    end
    return m;
  endfunction

endpackage

// File: rtl/simd_addxor_recon_chunk_csel_add.sv
// Dual-sum chunk adder: s0 = z+y, s1 = z+y+1, split at byte-aligned lane starts; XOR passes z^y.
// Purely combinational, no flow control.
module simd_addxor_recon_chunk_csel_add
  import simd_addxor_recon_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic                 add_en_i,
  input  logic [CHUNK_W-1:0]   z_i,
  input  logic [CHUNK_W-1:0]   y_i,
  input  logic [CHUNK_W/8-1:0] kill_i,
  output logic [CHUNK_W-1:0]   s0_o,
  output logic [CHUNK_W-1:0]   s1_o,
  output chunk_carry_t         cc_o
);

  localparam int NB = CHUNK_W / 8;

  always_comb begin
    logic       k0;
    logic       k1;
    logic [8:0] t0;
    logic [8:0] t1;
    s0_o = '0;
    s1_o = '0;
    cc_o = '0;
    k0   = 1'b0;
    k1   = 1'b1;
    t0   = '0;
    t1   = '0;
    if (add_en_i) begin
      for (int j = 0; j < NB; j++) begin
        // A byte that opens a lane never sees a carry from below.
        if (kill_i[j]) begin
          k0 = 1'b0;
          k1 = 1'b0;
        end
        t0 = {1'b0, z_i[j*8 +: 8]} + {1'b0, y_i[j*8 +: 8]} + {8'd0, k0};
        t1 = {1'b0, z_i[j*8 +: 8]} + {1'b0, y_i[j*8 +: 8]} + {8'd0, k1};
        s0_o[j*8 +: 8] = t0[7:0];
        s1_o[j*8 +: 8] = t1[7:0];
        k0 = t0[8];
        k1 = t1[8];
      end
      cc_o.c0 = k0;
      cc_o.c1 = k1;
    end else begin
      s0_o = z_i ^ y_i;
      s1_o = z_i ^ y_i;
    end
  end

endmodule

// File: rtl/simd_addxor_recon.sv
// Recombines masked share z with mask y (lane-wise add mod 2^w, or XOR); tag travels with the beat.
// Latency 2+EX_LATENCY, one beat/cycle; valid/ready with stalls rippling back to in_ready_o.
module simd_addxor_recon
  import simd_addxor_recon_pkg::*;
#(
  parameter int TAG_W      = 8,
  parameter int CHUNK_W    = 16,
  parameter int EX_LATENCY = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  prng_t            z_i,
  input  prng_t            y_i,
  input  mode_t            mode_i,
  input  width_t           width_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output prng_t            x_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int NC = P / CHUNK_W;
  localparam int NB = CHUNK_W / 8;

  prng_t                 lane_mask;
  logic [P/8-1:0]        byte_start;
  logic [NC-1:0]         ls_d;
  prng_t                 sum0_d;
  prng_t                 sum1_d;
  chunk_carry_t [NC-1:0] cc_d;

  always_comb begin
    lane_mask  = make_carry_mask(width_i);
    byte_start = '0;
    ls_d       = '0;
    for (int b = 0; b < P/8; b++) begin
      byte_start[b] = |lane_mask[b*8 +: 8];
    end
    for (int k = 0; k < NC; k++) begin
      ls_d[k] = byte_start[k*NB];
    end
  end

  for (genvar k = 0; k < NC; k++) begin : g_chunk
    simd_addxor_recon_chunk_csel_add #(
      .CHUNK_W (CHUNK_W)
    ) u_csel (
      .add_en_i (!mode_i.b),
      .z_i      (z_i[k*CHUNK_W +: CHUNK_W]),
      .y_i      (y_i[k*CHUNK_W +: CHUNK_W]),
      .kill_i   (byte_start[k*NB +: NB]),
      .s0_o     (sum0_d[k*CHUNK_W +: CHUNK_W]),
      .s1_o     (sum1_d[k*CHUNK_W +: CHUNK_W]),
      .cc_o     (cc_d[k])
    );
  end

  logic                  s1_vld_q;
  prng_t                 s1_sum0_q;
  prng_t                 s1_sum1_q;
  chunk_carry_t [NC-1:0] s1_cc_q;
  logic [NC-1:0]         s1_ls_q;
  logic [TAG_W-1:0]      s1_tag_q;
  logic                  s1_adv;
  logic                  s2_adv;

  assign s1_adv     = !s1_vld_q || s2_adv;
  assign in_ready_o = s1_adv;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld_q  <= 1'b0;
      s1_sum0_q <= '0;
      s1_sum1_q <= '0;
      s1_cc_q   <= '0;
      s1_ls_q   <= '0;
      s1_tag_q  <= '0;
    end else if (s1_adv) begin
      s1_vld_q <= in_valid_i;
      if (in_valid_i) begin
        s1_sum0_q <= sum0_d;
        s1_sum1_q <= sum1_d;
        s1_cc_q   <= cc_d;
        s1_ls_q   <= ls_d;
        s1_tag_q  <= tag_i;
      end
    end
  end

  // Carry-select across chunks; the chain restarts at each lane start, lane MSB carry is dropped.
  prng_t x_d;

  always_comb begin
    logic sel;
    sel = 1'b0;
    x_d = '0;
    for (int k = 0; k < NC; k++) begin
      if (s1_ls_q[k]) begin
        sel = 1'b0;
      end
      x_d[k*CHUNK_W +: CHUNK_W] = sel ? s1_sum1_q[k*CHUNK_W +: CHUNK_W]
                                      : s1_sum0_q[k*CHUNK_W +: CHUNK_W];
      sel = s1_cc_q[k].c0 | (s1_cc_q[k].c1 & sel);
    end
  end

  logic             s2_vld_q;
  prng_t            s2_x_q;
  logic [TAG_W-1:0] s2_tag_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_vld_q <= 1'b0;
      s2_x_q   <= '0;
      s2_tag_q <= '0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_x_q   <= x_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  if (EX_LATENCY == 0) begin : g_noex
    assign s2_adv      = !s2_vld_q || out_ready_i;
    assign out_valid_o = s2_vld_q;
    assign x_o         = s2_x_q;
    assign tag_o       = s2_tag_q;
  end else begin : g_ex
    logic                 ex_vld_q [EX_LATENCY];
    prng_t                ex_x_q   [EX_LATENCY];
    logic [TAG_W-1:0]     ex_tag_q [EX_LATENCY];
    logic [EX_LATENCY:0]  ex_adv;

    always_comb begin
      ex_adv             = '0;
      ex_adv[EX_LATENCY] = out_ready_i;
      for (int i = EX_LATENCY - 1; i >= 0; i--) begin
        ex_adv[i] = !ex_vld_q[i] || ex_adv[i+1];
      end
    end

    assign s2_adv = !s2_vld_q || ex_adv[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < EX_LATENCY; i++) begin
          ex_vld_q[i] <= 1'b0;
          ex_x_q[i]   <= '0;
          ex_tag_q[i] <= '0;
        end
      end else begin
        if (ex_adv[0]) begin
          ex_vld_q[0] <= s2_vld_q;
          if (s2_vld_q) begin
            ex_x_q[0]   <= s2_x_q;
            ex_tag_q[0] <= s2_tag_q;
          end
        end
        for (int i = 1; i < EX_LATENCY; i++) begin
          if (ex_adv[i]) begin
            ex_vld_q[i] <= ex_vld_q[i-1];
            if (ex_vld_q[i-1]) begin
              ex_x_q[i]   <= ex_x_q[i-1];
              ex_tag_q[i] <= ex_tag_q[i-1];
            end
          end
        end
      end
    end

    assign out_valid_o = ex_vld_q[EX_LATENCY-1];
    assign x_o         = ex_x_q[EX_LATENCY-1];
    assign tag_o       = ex_tag_q[EX_LATENCY-1];
  end

endmodule

// File: tb/tb_simd_addxor_recon.sv
// Bench for simd_addxor_recon: directed vector table, latency/backpressure/reset sequences,
// and random round-trip beats against a lane-arithmetic reference.
module tb_simd_addxor_recon;
  import simd_addxor_recon_pkg::*;

  localparam int EXL = 0;
  localparam int LAT = 2 + EXL;
  localparam int TW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  prng_t         z;
  prng_t         y;
  prng_t         x;
  mode_t         mode;
  width_t        width;
  logic [TW-1:0] tag;
  logic [TW-1:0] tag_out;

  always #5 clk = ~clk;

  simd_addxor_recon #(
    .TAG_W      (TW),
    .CHUNK_W    (16),
    .EX_LATENCY (EXL)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .z_i         (z),
    .y_i         (y),
    .mode_i      (mode),
    .width_i     (width),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .x_o         (x),
    .tag_o       (tag_out)
  );

  typedef struct {
    prng_t         x;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    prng_t      z;
    prng_t      y;
    logic       md;
    logic [1:0] wd;
    prng_t      ex;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic          got_out;
  logic [TW-1:0] got_tag;
  logic          acc;
  logic          stall_prev = 1'b0;
  prng_t         held_x;
  logic [TW-1:0] held_tag;
  vec_t          tbl[12];

  task automatic chk(input bit ok, input string name, input prng_t act, input prng_t req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Lane-wise subtraction: what the upstream subtract/XOR share stage would produce.
  function automatic prng_t lane_sub(input prng_t a, input prng_t b, input logic [1:0] wd);
    int    lw;
    prng_t m;
    prng_t r;
    lw = 8 << int'(wd);
    m  = (prng_t'(1) << lw) - prng_t'(1);
    r  = '0;
    for (int l = 0; l < P / lw; l++) begin
      r = r | ((((a >> (l * lw)) - (b >> (l * lw))) & m) << (l * lw));
    end
    return r;
  endfunction

  function automatic prng_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_beat(output prng_t zz, output prng_t yy, output prng_t xx,
                           output logic md, output logic [1:0] wd);
    xx = rnd128();
    yy = rnd128();
    md = 1'($urandom_range(0, 1));
    wd = 2'($urandom_range(0, 3));
    zz = md ? (xx ^ yy) : lane_sub(xx, yy, wd);
  endtask

  task automatic cycle(input logic v, input prng_t zz, input prng_t yy, input logic md,
                       input logic [1:0] wd, input logic [TW-1:0] tg, input logic rdy,
                       input prng_t ex);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    z         = zz;
    y         = yy;
    mode.b    = md;
    width     = width_t'(wd);
    tag       = tg;
    out_ready = rdy;
    @(negedge clk);
    got_out = out_valid && out_ready;
    got_tag = tag_out;
    acc     = in_valid && in_ready;
    if (stall_prev) begin
      chk(out_valid && (x == held_x), "held_x", x, held_x);
      chk(tag_out == held_tag, "held_tag", prng_t'(tag_out), prng_t'(held_tag));
    end
    stall_prev = out_valid && !out_ready;
    held_x     = x;
    held_tag   = tag_out;
    if (got_out) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_output", prng_t'(tag_out), '0);
      end else begin
        e = sb.pop_front();
        chk(x == e.x, "x_o", x, e.x);
        chk(tag_out == e.tag, "tag_o", prng_t'(tag_out), prng_t'(e.tag));
      end
    end
    if (acc) begin
      e.x   = ex;
      e.tag = tg;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, 1'b0, 2'd0, '0, rdy, '0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    chk(sb.size() == 0, name, prng_t'(sb.size()), '0);
  endtask

  task automatic set_vec(input int i, input prng_t zz, input prng_t yy, input logic md,
                         input logic [1:0] wd, input prng_t ex);
    tbl[i].z  = zz;
    tbl[i].y  = yy;
    tbl[i].md = md;
    tbl[i].wd = wd;
    tbl[i].ex = ex;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prng_t      rz;
    prng_t      ry;
    prng_t      rx;
    logic       rm;
    logic [1:0] rw;
    int         nacc;
    int         guard;

    set_vec(0,  {16{8'hFF}}, {16{8'h01}}, 1'b0, 2'd0, '0);
    set_vec(1,  {64'h1111_2222_3333_4444, 64'h0000_0000_FFFF_FFFF}, {64'h0, 64'h1}, 1'b0, 2'd3,
                {64'h1111_2222_3333_4444, 64'h0000_0001_0000_0000});
    set_vec(2,  {64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h0, 64'h1}, 1'b0, 2'd3,
                {64'h0123_4567_89AB_CDEF, 64'h0});
    set_vec(3,  {16{8'hA5}}, {16{8'hFF}}, 1'b1, 2'd2, {16{8'h5A}});
    set_vec(4,  {16{8'hA5}}, {16{8'h3C}}, 1'b1, 2'd0, {16{8'h99}});
    set_vec(5,  {8{16'hFFFF}}, {8{16'h0001}}, 1'b0, 2'd1, '0);
    set_vec(6,  {8{16'h00FF}}, {8{16'h0001}}, 1'b0, 2'd1, {8{16'h0100}});
    set_vec(7,  {4{32'h0000_FFFF}}, {4{32'h0000_0001}}, 1'b0, 2'd2, {4{32'h0001_0000}});
    set_vec(8,  {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, 1'b0, 2'd2, '0);
    set_vec(9,  {2{64'h0000_FFFF_FFFF_FFFF}}, {2{64'h1}}, 1'b0, 2'd3, {2{64'h0001_0000_0000_0000}});
    set_vec(10, {16{8'h7F}}, {16{8'h01}}, 1'b0, 2'd0, {16{8'h80}});
    set_vec(11, {2{64'h8000_0000_0000_0000}}, {2{64'h8000_0000_0000_0000}}, 1'b0, 2'd3, '0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z         = '0;
    y         = '0;
    mode.b    = 1'b0;
    width     = W8;
    tag       = '0;
    #12;
    chk(!out_valid, "reset_out_valid", prng_t'(out_valid), '0);
    chk(x == '0, "reset_x", x, '0);
    chk(tag_out == '0, "reset_tag", prng_t'(tag_out), '0);
    #11;
    rst_n = 1'b1;
    #4;
    chk(in_ready, "reset_in_ready", prng_t'(in_ready), prng_t'(1));

    // Directed vector table, one beat at a time.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tbl[i].z, tbl[i].y, tbl[i].md, tbl[i].wd, TW'(i), 1'b1, tbl[i].ex);
      drain("table_drain");
    end

    // Back-to-back 16 beats: outputs on consecutive cycles starting at cycle LAT.
    for (int c = 0; c < 16 + LAT + 2; c++) begin
      if (c < 16) begin
        rand_beat(rz, ry, rx, rm, rw);
        cycle(1'b1, rz, ry, rm, rw, TW'(c), 1'b1, rx);
        chk(acc, "b2b_accept", prng_t'(acc), prng_t'(1));
      end else begin
        idle(1'b1);
      end
      if (c >= LAT && c < 16 + LAT) begin
        chk(got_out && (got_tag == TW'(c - LAT)), "b2b_out_tag",
            prng_t'({got_out, got_tag}), prng_t'({1'b1, TW'(c - LAT)}));
      end else begin
        chk(!got_out, "b2b_no_out", prng_t'(got_out), '0);
      end
    end
    drain("b2b_drain");

    // Backpressure from empty: in_ready drops after LAT accepted beats, output held.
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      rand_beat(rz, ry, rx, rm, rw);
      cycle(1'b1, rz, ry, rm, rw, TW'(8'h40 + nacc), 1'b0, rx);
      chk(in_ready == (c < LAT), "bp_in_ready", prng_t'(in_ready), prng_t'(c < LAT));
      if (acc) nacc++;
      if (c >= LAT) begin
        chk(out_valid && (tag_out == 8'h40), "bp_out_held",
            prng_t'({out_valid, tag_out}), prng_t'({1'b1, 8'h40}));
      end
    end
    chk(nacc == LAT, "bp_accepted", prng_t'(nacc), prng_t'(LAT));
    guard = 0;
    while (nacc < 10 && guard < 40) begin
      rand_beat(rz, ry, rx, rm, rw);
      cycle(1'b1, rz, ry, rm, rw, TW'(8'h40 + nacc), 1'b1, rx);
      if (acc) nacc++;
      guard++;
    end
    chk(nacc == 10, "bp_release_budget", prng_t'(nacc), prng_t'(10));
    drain("bp_drain");

    // Random round-trip beats in mixed modes and widths with random stalls.
    nacc  = 0;
    guard = 0;
    while (nacc < 10000 && guard < 40000) begin
      rand_beat(rz, ry, rx, rm, rw);
      cycle(($urandom_range(0, 3) != 0), rz, ry, rm, rw, TW'(nacc),
            ($urandom_range(0, 3) != 0), rx);
      if (acc) nacc++;
      guard++;
    end
    chk(nacc == 10000, "random_budget", prng_t'(nacc), prng_t'(10000));
    drain("random_drain");

    // Asynchronous reset with two beats in flight.
    for (int c = 0; c < 2; c++) begin
      rand_beat(rz, ry, rx, rm, rw);
      cycle(1'b1, rz, ry, rm, rw, TW'(8'h80 + c), 1'b0, rx);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(!out_valid, "arst_out_valid", prng_t'(out_valid), '0);
    chk(x == '0, "arst_x", x, '0);
    chk(tag_out == '0, "arst_tag", prng_t'(tag_out), '0);
    in_valid   = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    #13;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      idle(1'b1);
      chk(!out_valid, "post_rst_no_stale", prng_t'(out_valid), '0);
      chk(in_ready, "post_rst_in_ready", prng_t'(in_ready), prng_t'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
